qenc_gen: RTL and testbench

//  Quadrature encoder signal generator: emits a programmed number of A/B quadrature

---
 rtl/qenc_gen.sv | 177 +++++++++++++++++
 tb/tb_qenc_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/qenc_gen.sv
// Quadrature encoder generator: emits a programmed number of A/B edges at a set rate and direction.
// Optional index output (rev counter, enc_z) enabled by defining QENC_INDEX_EN.
module qenc_gen #(
    parameter int CNT_W = 16,
    parameter int DIV_W = 16,
    parameter int POS_W = 32,
    parameter int CPR   = 64
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] steps,
    input  logic [DIV_W-1:0] period,
    output logic             busy,
    output logic             done,
    output logic             enc_a,
    output logic             enc_b,
    output logic             enc_z,
    output logic [POS_W-1:0] position
);

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

    if (CPR < 2) begin : g_cpr_check
        $error("qenc_gen: CPR must be at least 2");
    end

    state_t           state_q, state_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ph_q, ph_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             done_q, done_d;
    logic             accept_s, step_s, last_s;

    // AB is the 2-bit phase {A,B}; forward walks 00->10->11->01, reverse walks it backwards.
    function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic rev);
        logic [1:0] nxt;
        case ({rev, ph})
            3'b0_00: nxt = 2'b10;
            3'b0_10: nxt = 2'b11;
            3'b0_11: nxt = 2'b01;
            3'b0_01: nxt = 2'b00;
            3'b1_00: nxt = 2'b01;
            3'b1_01: nxt = 2'b11;
            3'b1_11: nxt = 2'b10;
            3'b1_10: nxt = 2'b00;
            default: nxt = 2'b00;
        endcase
        return nxt;
    endfunction

    assign accept_s = (state_q == IDLE) && start && (steps != CNT_ZERO);
    assign step_s   = (state_q == RUN) && (cnt_q == DIV_W'(0));
    assign last_s   = step_s && (rem_q == CNT_ONE);

    // FSM state register
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept_s ? RUN : IDLE;
            RUN:     state_d = last_s ? IDLE : RUN;
            default: state_d = IDLE;
        endcase
    end

    // Move datapath: latch on accept, then the divider reloads at every emitted edge
    always_comb begin
        dir_d  = dir_q;
        rem_d  = rem_q;
        per_d  = per_q;
        cnt_d  = cnt_q;
        ph_d   = ph_q;
        pos_d  = pos_q;
        done_d = 1'b0;
        if (accept_s) begin
            dir_d = dir;
            rem_d = steps;
            per_d = (period == DIV_W'(0)) ? DIV_ONE : period;
            cnt_d = per_d - DIV_ONE;
        end else if (step_s) begin
            rem_d  = rem_q - CNT_ONE;
            cnt_d  = per_q - DIV_ONE;
            ph_d   = next_phase(ph_q, dir_q);
            pos_d  = dir_q ? (pos_q - POS_ONE) : (pos_q + POS_ONE);
            done_d = last_s;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q - DIV_ONE;
        end else begin
            // zero-length move: acknowledge with done, never leave IDLE
            done_d = start && (steps == CNT_ZERO);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            dir_q  <= 1'b0;
            rem_q  <= CNT_ZERO;
            per_q  <= DIV_ONE;
            cnt_q  <= DIV_W'(0);
            ph_q   <= 2'b00;
            pos_q  <= POS_W'(0);
            done_q <= 1'b0;
        end else begin
            dir_q  <= dir_d;
            rem_q  <= rem_d;
            per_q  <= per_d;
            cnt_q  <= cnt_d;
            ph_q   <= ph_d;
            pos_q  <= pos_d;
            done_q <= done_d;
        end
    end

`ifdef QENC_INDEX_EN
    localparam int REV_W = $clog2(CPR);
    localparam logic [REV_W-1:0] REV_MAX = REV_W'(CPR - 1);

    logic [REV_W-1:0] rev_q, rev_d;
    logic             enc_z_q, enc_z_d;

    // Revolution counter follows each edge, wrapping at CPR in either direction
    always_comb begin
        rev_d = rev_q;
        if (step_s) begin
            if (!dir_q) begin
                rev_d = (rev_q == REV_MAX) ? REV_W'(0) : (rev_q + REV_W'(1));
            end else begin
                rev_d = (rev_q == REV_W'(0)) ? REV_MAX : (rev_q - REV_W'(1));
            end
        end else begin
            rev_d = rev_q;
        end
        enc_z_d = (rev_d == REV_W'(0));
    end

    // Index registers
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rev_q   <= REV_W'(0);
            enc_z_q <= 1'b1;
        end else begin
            rev_q   <= rev_d;
            enc_z_q <= enc_z_d;
        end
    end

    assign enc_z = enc_z_q;
`else
    assign enc_z = 1'b0;
`endif

    assign busy     = (state_q == RUN);
    assign done     = done_q;
    assign enc_a    = ph_q[1];
    assign enc_b    = ph_q[0];
    assign position = pos_q;

endmodule

// File: tb/tb_qenc_gen.sv
// Self-checking bench for qenc_gen: move table, hand-written corner sequences and random
// moves, all checked every cycle against a time-scheduled reference model.
module tb_qenc_gen;
    localparam int CNT_W = 16;
    localparam int DIV_W = 16;
    localparam int POS_W = 32;
    localparam int CPR   = 4;
`ifdef QENC_INDEX_EN
    localparam bit IDX_EN = 1'b1;
`else
    localparam bit IDX_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstb = 1'b1;
    logic             start = 1'b0;
    logic             dir = 1'b0;
    logic [CNT_W-1:0] steps = '0;
    logic [DIV_W-1:0] period = '0;
    logic             busy, done, enc_a, enc_b, enc_z;
    logic [POS_W-1:0] position;

    int n_chk = 0;
    int n_fail = 0;

    qenc_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W), .CPR(CPR)) dut (
        .clk(clk), .rstb(rstb), .start(start), .dir(dir), .steps(steps), .period(period),
        .busy(busy), .done(done), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
        .position(position)
    );

    always #5 clk = ~clk;

    // Reference model: edge k of a move accepted at cycle t0 lands on cycle t0 + k*P
    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int m_idx, m_pos, m_cyc, m_t0, m_p, m_n, m_k;
    bit m_dir, m_busy, m_done;

    always @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            m_idx = 0; m_pos = 0; m_cyc = 0; m_t0 = 0; m_p = 1; m_n = 0; m_k = 0;
            m_dir = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else begin
            m_cyc++;
            m_done = 1'b0;
            if (m_busy) begin
                if (m_cyc == m_t0 + m_k * m_p) begin
                    m_idx = m_dir ? (m_idx + 3) % 4 : (m_idx + 1) % 4;
                    m_pos = m_dir ? m_pos - 1 : m_pos + 1;
                    if (m_k == m_n) begin
                        m_busy = 1'b0;
                        m_done = 1'b1;
                    end else begin
                        m_k++;
                    end
                end
            end else if (start) begin
                if (steps == 0) begin
                    m_done = 1'b1;
                end else begin
                    m_busy = 1'b1; m_t0 = m_cyc; m_k = 1; m_n = int'(steps);
                    m_p = (period == 0) ? 1 : int'(period); m_dir = dir;
                end
            end
        end
    end

    function automatic bit exp_z(input int pos);
        int r;
        r = ((pos % CPR) + CPR) % CPR;
        return IDX_EN && (r == 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_cycle();
        logic [36:0] got, want;
        got  = {enc_a, enc_b, busy, done, enc_z, position};
        want = {seq[m_idx], m_busy, m_done, exp_z(m_pos), 32'(m_pos)};
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL cycle @%0t: got ab=%b%b busy=%b done=%b z=%b pos=%0d, required ab=%b busy=%b done=%b z=%b pos=%0d",
                     $time, enc_a, enc_b, busy, done, enc_z, $signed(position),
                     seq[m_idx], m_busy, m_done, exp_z(m_pos), m_pos);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run_move(input bit d, input logic [CNT_W-1:0] s, input logic [DIV_W-1:0] p,
                            output int lat);
        start = 1'b1; dir = d; steps = s; period = p;
        tick();
        start = 1'b0;
        chk("busy_after_accept", {31'b0, busy}, {31'b0, (s != 0)});
        lat = 0;
        while (!done && lat < 2000) begin
            tick();
            lat++;
        end
        if (!done) chk("move_timeout", 32'(lat), 32'(-1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstb = 1'b0;
        #1;
        chk("rst_ab", {30'b0, enc_a, enc_b}, 32'd0);
        chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
        chk("rst_pos", position, 32'd0);
        chk("rst_z", {31'b0, enc_z}, {31'b0, IDX_EN});
        @(negedge clk);
        rstb = 1'b1;
    endtask

    typedef struct {
        bit               d;
        logic [CNT_W-1:0] s;
        logic [DIV_W-1:0] p;
        logic [1:0]       ab;
        int               pos;
        int               lat;
    } vec_t;

    vec_t vt [6];
    int lat;

    initial begin
        vt[0] = '{1'b0, 16'd4, 16'd3, 2'b00,  4, 12};
        vt[1] = '{1'b1, 16'd2, 16'd0, 2'b11,  2,  2};
        vt[2] = '{1'b0, 16'd1, 16'd2, 2'b01,  3,  2};
        vt[3] = '{1'b1, 16'd5, 16'd1, 2'b11, -2,  5};
        vt[4] = '{1'b0, 16'd3, 16'd4, 2'b10,  1, 12};
        vt[5] = '{1'b1, 16'd0, 16'd3, 2'b10,  1,  0};

        #2 rstb = 1'b0;
        #20;
        chk("rst_ab", {30'b0, enc_a, enc_b}, 32'd0);
        chk("rst_busy_done", {30'b0, busy, done}, 32'd0);
        chk("rst_pos", position, 32'd0);
        chk("rst_z", {31'b0, enc_z}, {31'b0, IDX_EN});
        @(negedge clk);
        rstb = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_move(vt[i].d, vt[i].s, vt[i].p, lat);
            chk($sformatf("vec%0d_ab", i), {30'b0, enc_a, enc_b}, {30'b0, vt[i].ab});
            chk($sformatf("vec%0d_pos", i), position, 32'(vt[i].pos));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].lat));
            chk($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'd0);
            tick();
            chk($sformatf("vec%0d_done_pulse", i), {31'b0, done}, 32'd0);
        end

        // Index: enc_z high after forward steps 4 and 8, low one step back, high again
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            run_move(1'b0, 16'd1, 16'd1, lat);
            chk($sformatf("idx_fwd%0d", k), {31'b0, enc_z}, {31'b0, IDX_EN && (k % 4 == 0)});
        end
        run_move(1'b1, 16'd1, 16'd1, lat);
        chk("idx_rev", {31'b0, enc_z}, 32'd0);
        run_move(1'b0, 16'd1, 16'd1, lat);
        chk("idx_fwd_again", {31'b0, enc_z}, {31'b0, IDX_EN});

        // start pulses and input changes while busy are ignored (from AB=00, pos=8)
        start = 1'b1; dir = 1'b0; steps = 16'd6; period = 16'd2;
        tick();
        lat = 0;
        while (!done && lat < 200) begin
            start = (lat % 3 == 1); dir = 1'b1; steps = 16'd1; period = 16'd1;
            tick();
            lat++;
        end
        start = 1'b0;
        chk("ign_lat", 32'(lat), 32'd12);
        chk("ign_ab", {30'b0, enc_a, enc_b}, 32'b11);
        chk("ign_pos", position, 32'd14);

        // Reset mid-move after 2 of 10 edges
        tick();
        start = 1'b1; dir = 1'b0; steps = 16'd10; period = 16'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_pos", position, 32'd16);
        do_reset();
        tick();
        run_move(1'b0, 16'd1, 16'd1, lat);
        chk("post_rst_ab", {30'b0, enc_a, enc_b}, 32'b10);
        chk("post_rst_pos", position, 32'd1);

        // Random moves with random traffic on the inputs while busy
        for (int m = 0; m < 25; m++) begin
            int n;
            tick();
            start = 1'b1; dir = 1'($urandom_range(0, 1));
            steps = 16'($urandom_range(0, 10)); period = 16'($urandom_range(0, 4));
            tick();
            n = 0;
            while (!done && n < 200) begin
                start = ($urandom_range(0, 2) == 0); dir = 1'($urandom_range(0, 1));
                steps = 16'($urandom_range(0, 20)); period = 16'($urandom_range(0, 5));
                tick();
                n++;
            end
            start = 1'b0;
            if (!done) chk("rand_timeout", 32'(n), 32'(-1));
        end
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
